// File: rtl/frame_decrypter.sv
// rtl/frame_decrypter.sv - streams one frame from a source buffer to a destination buffer with a per-pixel transform
//
// Purpose: reads FRAME_PIXELS pixels in address order, applies the transform
// selected at frame start (bypass, XOR with key, masked substitute) and writes
// each pixel to the same address, RD_LAT+1 cycles after its read strobe.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   start, abort        begin a frame (IDLE only) / terminate the current frame
//   mode, key           transform select and key / substitute value
//   match_mask/val      substitute compare mask and value
//   rd_en/rd_addr       source read strobe and address
//   rd_data             source pixel, valid RD_LAT cycles after rd_en
//   wr_en/wr_addr/data  destination write strobe, address and pixel
//   busy, done          frame in progress / one-cycle completion pulse
//   frame_cnt           completed frame count, wraps at 256

module frame_decrypter #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 15,
    parameter int FRAME_PIXELS = 30625,
    parameter int RD_LAT       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] match_mask,
    input  logic [DATA_W-1:0] match_val,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_key;
    logic [DATA_W-1:0]   r_mask;
    logic [DATA_W-1:0]   r_val;
    // r_vld[k] marks a read issued k+1 cycles ago; the top bit lines up with rd_data
    logic [RD_LAT-1:0]   r_vld;
    logic [ADDR_W-1:0]   r_wr_next;
    logic                w_accept;
    logic                w_cap;
    logic                w_cap_last;
    logic [DATA_W-1:0]   w_xform;

    assign w_accept   = (r_state == S_IDLE) && start && !abort;
    // abort drops whatever is still in flight, including a capture in the same cycle
    assign w_cap      = r_vld[RD_LAT-1] && !abort;
    assign w_cap_last = w_cap && (r_wr_next == LAST);

    always_comb begin
        w_xform = rd_data;
        case (r_mode)
            2'b01:   w_xform = rd_data ^ r_key;
            2'b10:   if ((rd_data & r_mask) == (r_val & r_mask)) w_xform = r_key;
            default: w_xform = rd_data;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start && !abort) w_next = S_RUN;
            S_RUN: begin
                if (abort)                w_next = S_IDLE;
                else if (rd_addr == LAST) w_next = S_DRAIN;
            end
            // done is high during the write of the last pixel, so leave on that cycle
            S_DRAIN: if (abort || done)   w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_mode    <= '0;
            r_key     <= '0;
            r_mask    <= '0;
            r_val     <= '0;
            r_vld     <= '0;
            r_wr_next <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            r_state <= w_next;
            rd_en   <= (w_next == S_RUN);
            busy    <= (w_next != S_IDLE);
            wr_en   <= w_cap;
            done    <= w_cap_last;

            if (w_accept) begin
                r_mode    <= mode;
                r_key     <= key;
                r_mask    <= match_mask;
                r_val     <= match_val;
                rd_addr   <= '0;
                r_wr_next <= '0;
            end else if (r_state == S_RUN && w_next == S_RUN) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end

            if (abort) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= rd_en;
                for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
            end

            if (w_cap) begin
                wr_addr <= r_wr_next;
                wr_data <= w_xform;
                if (r_wr_next != LAST) r_wr_next <= r_wr_next + ADDR_W'(1);
            end

            if (w_cap_last) frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule
